// File: rtl/target.sv
// Bus-side responder: captures address/data strobes, owns a byte-wide register
// memory and completes each transfer with an ack. Reads are answered inline
// (optionally after a fixed delay) or as split transactions that re-arbitrate
// for the bus before returning data.
module target #(
  parameter int unsigned MEM_ADDR_W    = 6,
  parameter logic [7:0]  MEM_INIT_XOR  = 8'h00,
  parameter int unsigned READ_LATENCY  = 0,
  parameter bit          SPLIT_EN      = 1'b0,
  parameter int unsigned SPLIT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] tgt_addr_in,
  input  logic        tgt_addr_in_valid,
  input  logic [7:0]  tgt_data_in,
  input  logic        tgt_data_in_valid,
  input  logic        tgt_rw,
  output logic        tgt_ready,
  output logic        tgt_ack,
  output logic        tgt_split_ack,
  output logic [7:0]  tgt_data_out,
  output logic        tgt_data_out_valid,
  output logic        tgt_split_req,
  input  logic        tgt_split_grant
);

  localparam int         DEPTH          = 1 << MEM_ADDR_W;
  // Counters are loaded with latency-1 so the wait state lasts exactly
  // `latency` cycles, including the cycle the state is entered.
  localparam logic [7:0] RD_CNT_INIT    = (READ_LATENCY  > 0) ? 8'(READ_LATENCY  - 1) : 8'd0;
  localparam logic [7:0] SPLIT_CNT_INIT = (SPLIT_LATENCY > 0) ? 8'(SPLIT_LATENCY - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_COLLECT,
    S_WR_ACK,
    S_RD_DELAY,
    S_RD_RESP,
    S_SPLIT_WAIT,
    S_SPLIT_REQ,
    S_SPLIT_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    data_vld_q, data_vld_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              mem_q [DEPTH];

  logic                    wr_en;
  logic                    ready_q, ready_d;
  logic                    ack_q, ack_d;
  logic                    split_ack_q, split_ack_d;
  logic                    split_req_q, split_req_d;
  logic [7:0]              dout_q, dout_d;
  logic                    dval_q, dval_d;

  // The bus decoder has already selected this target; the high address bits
  // carry no information here.
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^tgt_addr_in[15:MEM_ADDR_W];

  // Next-state logic: transfer sequencing and capture of address/data.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    data_vld_d = data_vld_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (tgt_addr_in_valid) begin
          addr_d = tgt_addr_in[MEM_ADDR_W-1:0];
          if (tgt_rw) begin
            if (tgt_data_in_valid) begin
              data_d     = tgt_data_in;
              data_vld_d = 1'b1;
            end
            state_d = (tgt_data_in_valid || data_vld_q) ? S_WR_ACK : S_WR_COLLECT;
          end else begin
            // A read makes any data that arrived ahead of an address stale.
            data_vld_d = 1'b0;
            if (SPLIT_EN) begin
              state_d = S_SPLIT_WAIT;
              cnt_d   = SPLIT_CNT_INIT;
            end else if (READ_LATENCY > 0) begin
              state_d = S_RD_DELAY;
              cnt_d   = RD_CNT_INIT;
            end else begin
              state_d = S_RD_RESP;
            end
          end
        end else if (tgt_data_in_valid) begin
          // Data may precede its address; hold it until the address shows up.
          data_d     = tgt_data_in;
          data_vld_d = 1'b1;
        end
      end

      S_WR_COLLECT: begin
        if (tgt_data_in_valid) begin
          data_d     = tgt_data_in;
          data_vld_d = 1'b1;
          state_d    = S_WR_ACK;
        end
      end

      S_WR_ACK: begin
        data_vld_d = 1'b0;
        state_d    = S_IDLE;
      end

      S_RD_DELAY: begin
        if (cnt_q == 8'd0) state_d = S_RD_RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end

      S_RD_RESP: state_d = S_IDLE;

      S_SPLIT_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_SPLIT_REQ;
        else               cnt_d   = cnt_q - 8'd1;
      end

      S_SPLIT_REQ: begin
        if (tgt_split_grant) state_d = S_SPLIT_RESP;
      end

      S_SPLIT_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Output next values, derived from the state being entered so every output
  // leaves a flop.
  always_comb begin
    wr_en       = (state_d == S_WR_ACK);
    ready_d     = (state_d inside {S_IDLE, S_WR_COLLECT});
    ack_d       = (state_d inside {S_WR_ACK, S_RD_RESP, S_SPLIT_RESP});
    dval_d      = (state_d inside {S_RD_RESP, S_SPLIT_RESP});
    split_ack_d = (state_d == S_SPLIT_WAIT) && (state_q != S_SPLIT_WAIT);
    split_req_d = (state_d == S_SPLIT_REQ);
    dout_d      = dval_d ? mem_q[addr_d] : dout_q;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= 8'h00;
      data_vld_q  <= 1'b0;
      cnt_q       <= 8'h00;
      ready_q     <= 1'b1;
      ack_q       <= 1'b0;
      split_ack_q <= 1'b0;
      split_req_q <= 1'b0;
      dout_q      <= 8'h00;
      dval_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      data_vld_q  <= data_vld_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      split_ack_q <= split_ack_d;
      split_req_q <= split_req_d;
      dout_q      <= dout_d;
      dval_q      <= dval_d;
    end
  end

  // Register memory: written on the edge that enters the write-ack state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the memory is deliberately part of the reset domain because its
      // contents after reset are architecturally defined, so it is built
      // from resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'(i) ^ MEM_INIT_XOR;
    end else if (wr_en) begin
      mem_q[addr_d] <= data_d;
    end
  end

  assign tgt_ready          = ready_q;
  assign tgt_ack            = ack_q;
  assign tgt_split_ack      = split_ack_q;
  assign tgt_split_req      = split_req_q;
  assign tgt_data_out       = dout_q;
  assign tgt_data_out_valid = dval_q;

endmodule

// File: tb/tb_target.sv
// Bench for target: three instances (inline read, split read, delayed read
// with non-zero init pattern) driven by per-instance input buses. Expected
// read data comes from a reference memory model and travels through a
// scoreboard queue from stimulus to response.
`timescale 1ns/1ps
module tb_target;
  localparam int N = 3;
  localparam logic [7:0] INIT_XOR [N] = '{8'h00, 8'h00, 8'h5A};

  typedef struct {
    int         dut;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr_in [N];
  logic        addr_v  [N];
  logic [7:0]  data_in [N];
  logic        data_v  [N];
  logic        rw      [N];
  logic        grant   [N];
  logic        ready   [N];
  logic        ack     [N];
  logic        sack    [N];
  logic [7:0]  dout    [N];
  logic        dval    [N];
  logic        sreq    [N];

  logic [7:0]  model [N][64];
  exp_t        exp_q [$];
  int          tests_run    = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  target #(.MEM_ADDR_W(6), .MEM_INIT_XOR(8'h00), .READ_LATENCY(0), .SPLIT_EN(1'b0), .SPLIT_LATENCY(4)) u_inline (
    .clk(clk), .rst_n(rst_n),
    .tgt_addr_in(addr_in[0]), .tgt_addr_in_valid(addr_v[0]),
    .tgt_data_in(data_in[0]), .tgt_data_in_valid(data_v[0]), .tgt_rw(rw[0]),
    .tgt_ready(ready[0]), .tgt_ack(ack[0]), .tgt_split_ack(sack[0]),
    .tgt_data_out(dout[0]), .tgt_data_out_valid(dval[0]),
    .tgt_split_req(sreq[0]), .tgt_split_grant(grant[0]));

  target #(.MEM_ADDR_W(6), .MEM_INIT_XOR(8'h00), .READ_LATENCY(0), .SPLIT_EN(1'b1), .SPLIT_LATENCY(4)) u_split (
    .clk(clk), .rst_n(rst_n),
    .tgt_addr_in(addr_in[1]), .tgt_addr_in_valid(addr_v[1]),
    .tgt_data_in(data_in[1]), .tgt_data_in_valid(data_v[1]), .tgt_rw(rw[1]),
    .tgt_ready(ready[1]), .tgt_ack(ack[1]), .tgt_split_ack(sack[1]),
    .tgt_data_out(dout[1]), .tgt_data_out_valid(dval[1]),
    .tgt_split_req(sreq[1]), .tgt_split_grant(grant[1]));

  target #(.MEM_ADDR_W(6), .MEM_INIT_XOR(8'h5A), .READ_LATENCY(2), .SPLIT_EN(1'b0), .SPLIT_LATENCY(4)) u_delay (
    .clk(clk), .rst_n(rst_n),
    .tgt_addr_in(addr_in[2]), .tgt_addr_in_valid(addr_v[2]),
    .tgt_data_in(data_in[2]), .tgt_data_in_valid(data_v[2]), .tgt_rw(rw[2]),
    .tgt_ready(ready[2]), .tgt_ack(ack[2]), .tgt_split_ack(sack[2]),
    .tgt_data_out(dout[2]), .tgt_data_out_valid(dval[2]),
    .tgt_split_req(sreq[2]), .tgt_split_grant(grant[2]));

  task automatic init_model();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 64; i++) model[k][i] = 8'(i) ^ INIT_XOR[k];
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < N; k++) begin
      addr_in[k] = 16'h0000; addr_v[k] = 1'b0; data_in[k] = 8'h00;
      data_v[k]  = 1'b0;     rw[k]     = 1'b0; grant[k]   = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    init_model();
    @(negedge clk);
  endtask

  // One-cycle address strobe; returns at the negedge one cycle after capture.
  task automatic strobe(input int k, input logic [15:0] a, input logic w,
                        input logic dv, input logic [7:0] d);
    addr_in[k] = a; addr_v[k] = 1'b1; rw[k] = w; data_v[k] = dv; data_in[k] = d;
    @(negedge clk);
    addr_v[k] = 1'b0; data_v[k] = 1'b0; rw[k] = 1'b0;
  endtask

  // Latency in cycles after the capture edge; -1 when the budget runs out.
  task automatic wait_ack(input int k, input int budget, output int lat);
    lat = 1;
    while (ack[k] !== 1'b1 && lat <= budget) begin
      @(negedge clk);
      lat++;
    end
    if (lat > budget) lat = -1;
  endtask

  task automatic do_write(input int k, input logic [15:0] a, input logic [7:0] d, output int lat);
    strobe(k, a, 1'b1, 1'b1, d);
    wait_ack(k, 10, lat);
    model[k][a[5:0]] = d;
    @(negedge clk);
  endtask

  task automatic do_read(input int k, input logic [15:0] a, output int lat,
                         output logic [7:0] d, output logic v);
    strobe(k, a, 1'b0, 1'b0, 8'h00);
    wait_ack(k, 40, lat);
    d = dout[k];
    v = dval[k];
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      tests_run++;
      if ({ready[k], ack[k], sack[k], dval[k], sreq[k], dout[k]} !== 13'h1000) begin
        tests_failed++;
        $display("FAIL reset_outputs dut%0d: got rdy=%b ack=%b sack=%b dval=%b sreq=%b dout=%h, expected rdy=1 others 0",
                 k, ready[k], ack[k], sack[k], dval[k], sreq[k], dout[k]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] d; logic v; exp_t e;
    do_write(0, 16'h0012, 8'hAA, lat);
    tests_run++;
    if (lat != 1) begin tests_failed++; $display("FAIL wr_0012_lat: got %0d, expected 1", lat); end
    tests_run++;
    if (ack[0] !== 1'b0) begin tests_failed++; $display("FAIL wr_ack_pulse: ack still %b, expected 0", ack[0]); end

    exp_q.push_back('{0, model[0][6'h12]});
    do_read(0, 16'h0012, lat, d, v);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 1 || v !== 1'b1 || d !== e.data || e.dut != 0) begin
      tests_failed++;
      $display("FAIL rd_0012: got lat=%0d valid=%b data=%h, expected lat=1 valid=1 data=%h", lat, v, d, e.data);
    end

    exp_q.push_back('{0, model[0][6'h34]});
    do_read(0, 16'h0034, lat, d, v);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 1 || v !== 1'b1 || d !== e.data) begin
      tests_failed++;
      $display("FAIL rd_0034: got lat=%0d valid=%b data=%h, expected lat=1 valid=1 data=%h", lat, v, d, e.data);
    end
    tests_run++;
    if (dout[0] !== e.data || dval[0] !== 1'b0 || ack[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL dout_hold: got dout=%h valid=%b ack=%b, expected dout=%h valid=0 ack=0", dout[0], dval[0], ack[0], e.data);
    end
  endtask

  task automatic test_data_first();
    int lat; logic [7:0] d; logic v; exp_t e;
    // Data two cycles ahead of its address.
    data_in[0] = 8'h5C; data_v[0] = 1'b1;
    @(negedge clk);
    data_v[0] = 1'b0;
    @(negedge clk);
    strobe(0, 16'h0003, 1'b1, 1'b0, 8'h00);
    wait_ack(0, 10, lat);
    model[0][3] = 8'h5C;
    @(negedge clk);
    tests_run++;
    if (lat != 1) begin tests_failed++; $display("FAIL data_first_lat: got %0d, expected 1", lat); end
    exp_q.push_back('{0, model[0][3]});
    do_read(0, 16'h0003, lat, d, v);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 1 || v !== 1'b1 || d !== e.data) begin
      tests_failed++;
      $display("FAIL data_first_rd: got lat=%0d valid=%b data=%h, expected lat=1 valid=1 data=%h", lat, v, d, e.data);
    end

    // Latched data is discarded by a read; the next write must wait for data.
    data_in[0] = 8'h77; data_v[0] = 1'b1;
    @(negedge clk);
    data_v[0] = 1'b0;
    exp_q.push_back('{0, model[0][5]});
    do_read(0, 16'h0005, lat, d, v);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 1 || d !== e.data) begin
      tests_failed++;
      $display("FAIL discard_rd: got lat=%0d data=%h, expected lat=1 data=%h", lat, d, e.data);
    end
    strobe(0, 16'h0006, 1'b1, 1'b0, 8'h00);
    tests_run++;
    if (ack[0] !== 1'b0 || ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_collect: got ack=%b ready=%b, expected ack=0 ready=1", ack[0], ready[0]);
    end
    // A second address strobe while collecting data is ignored.
    strobe(0, 16'h0007, 1'b1, 1'b0, 8'h00);
    data_in[0] = 8'h99; data_v[0] = 1'b1;
    @(negedge clk);
    data_v[0] = 1'b0;
    tests_run++;
    if (ack[0] !== 1'b1) begin tests_failed++; $display("FAIL collect_ack: got ack=%b, expected 1", ack[0]); end
    model[0][6] = 8'h99;
    @(negedge clk);
    for (int i = 6; i <= 7; i++) begin
      exp_q.push_back('{0, model[0][i]});
      do_read(0, 16'(i), lat, d, v);
      e = exp_q.pop_front();
      tests_run++;
      if (lat != 1 || d !== e.data) begin
        tests_failed++;
        $display("FAIL collect_rd_%0d: got lat=%0d data=%h, expected lat=1 data=%h", i, lat, d, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] d; logic v; exp_t e;
    logic [5:0] idx; logic [15:0] a;
    for (int i = 0; i < 8; i++) begin
      idx = 6'(i * 9 + 20);
      a   = {10'($urandom_range(0, 1023)), idx};
      do_write(0, a, 8'($urandom), lat);
      tests_run++;
      if (lat != 1) begin tests_failed++; $display("FAIL b2b_wr_%0d: got lat %0d, expected 1", i, lat); end
    end
    for (int i = 0; i < 8; i++) begin
      idx = 6'(i * 9 + 20);
      a   = {10'($urandom_range(0, 1023)), idx};
      exp_q.push_back('{0, model[0][idx]});
      do_read(0, a, lat, d, v);
      e = exp_q.pop_front();
      tests_run++;
      if (lat != 1 || v !== 1'b1 || d !== e.data) begin
        tests_failed++;
        $display("FAIL b2b_rd_%0d: got lat=%0d valid=%b data=%h, expected lat=1 valid=1 data=%h", i, lat, v, d, e.data);
      end
    end
  endtask

  task automatic test_read_latency();
    int lat; logic [7:0] d; logic v; exp_t e;
    exp_q.push_back('{2, model[2][6'h10]});
    do_read(2, 16'h0010, lat, d, v);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 3 || v !== 1'b1 || d !== e.data) begin
      tests_failed++;
      $display("FAIL delay_rd_init: got lat=%0d valid=%b data=%h, expected lat=3 valid=1 data=%h", lat, v, d, e.data);
    end
    do_write(2, 16'h0010, 8'h3C, lat);
    exp_q.push_back('{2, model[2][6'h10]});
    do_read(2, 16'h0010, lat, d, v);
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 3 || d !== e.data) begin
      tests_failed++;
      $display("FAIL delay_rd_raw: got lat=%0d data=%h, expected lat=3 data=%h", lat, d, e.data);
    end
  endtask

  task automatic test_split_delayed_grant();
    int lat; exp_t e; bit bad;
    grant[1] = 1'b0;
    exp_q.push_back('{1, model[1][6'h34]});
    strobe(1, 16'h0034, 1'b0, 1'b0, 8'h00);
    tests_run++;
    if ({sack[1], sreq[1], ack[1], ready[1]} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL split_ack_p1: got sack=%b sreq=%b ack=%b ready=%b, expected 1 0 0 0", sack[1], sreq[1], ack[1], ready[1]);
    end
    @(negedge clk);
    tests_run++;
    if (sack[1] !== 1'b0) begin tests_failed++; $display("FAIL split_ack_pulse: got %b, expected 0", sack[1]); end
    lat = 2;
    while (sreq[1] !== 1'b1 && lat <= 20) begin @(negedge clk); lat++; end
    tests_run++;
    if (lat != 5) begin tests_failed++; $display("FAIL split_req_rise: got cycle %0d, expected 5", lat); end
    bad = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (sreq[1] !== 1'b1 || ack[1] !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin tests_failed++; $display("FAIL split_req_hold: got early ack or dropped req, expected req held without ack"); end
    grant[1] = 1'b1;
    @(negedge clk);
    grant[1] = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if ({ack[1], dval[1], sreq[1]} !== 3'b110 || dout[1] !== e.data) begin
      tests_failed++;
      $display("FAIL split_resp: got ack=%b valid=%b sreq=%b data=%h, expected 1 1 0 data=%h", ack[1], dval[1], sreq[1], dout[1], e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_split_early_grant();
    int lat; logic [7:0] d; logic v; exp_t e;
    grant[1] = 1'b1;
    exp_q.push_back('{1, model[1][6'h21]});
    do_read(1, 16'h0021, lat, d, v);
    grant[1] = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 6 || v !== 1'b1 || d !== e.data) begin
      tests_failed++;
      $display("FAIL split_early_grant: got lat=%0d valid=%b data=%h, expected lat=6 valid=1 data=%h", lat, v, d, e.data);
    end
  endtask

  task automatic test_split_ignore();
    int lat; logic [7:0] d; logic v; exp_t e; int cyc;
    grant[1] = 1'b0;
    exp_q.push_back('{1, model[1][6'h20]});
    strobe(1, 16'h0020, 1'b0, 1'b0, 8'h00);
    cyc = 1;
    while (sreq[1] !== 1'b1 && cyc <= 20) begin @(negedge clk); cyc++; end
    tests_run++;
    if (ready[1] !== 1'b0 || cyc > 20) begin
      tests_failed++;
      $display("FAIL ready_in_split_req: got ready=%b after %0d cycles, expected ready=0 with req", ready[1], cyc);
    end
    strobe(1, 16'h0020, 1'b1, 1'b1, 8'hEE);
    tests_run++;
    if (ack[1] !== 1'b0 || sreq[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignore_strobe: got ack=%b sreq=%b, expected ack=0 sreq=1", ack[1], sreq[1]);
    end
    grant[1] = 1'b1;
    @(negedge clk);
    grant[1] = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (ack[1] !== 1'b1 || dout[1] !== e.data) begin
      tests_failed++;
      $display("FAIL ignore_resp: got ack=%b data=%h, expected ack=1 data=%h", ack[1], dout[1], e.data);
    end
    @(negedge clk);
    grant[1] = 1'b1;
    exp_q.push_back('{1, model[1][6'h20]});
    do_read(1, 16'h0020, lat, d, v);
    grant[1] = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 6 || d !== e.data) begin
      tests_failed++;
      $display("FAIL mem_unchanged: got lat=%0d data=%h, expected lat=6 data=%h", lat, d, e.data);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] d; logic v; exp_t e; int cyc; bit bad;
    do_write(1, 16'h0011, 8'hC3, lat);
    grant[1] = 1'b0;
    strobe(1, 16'h0011, 1'b0, 1'b0, 8'h00);
    cyc = 1;
    while (sreq[1] !== 1'b1 && cyc <= 20) begin @(negedge clk); cyc++; end
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    tests_run++;
    if (sreq[1] !== 1'b0 || ready[1] !== 1'b1 || cyc > 20) begin
      tests_failed++;
      $display("FAIL async_reset: got sreq=%b ready=%b, expected sreq=0 ready=1", sreq[1], ready[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    init_model();
    bad = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if ({ready[1], ack[1], sack[1], dval[1], sreq[1], dout[1]} !== 13'h1000) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin tests_failed++; $display("FAIL reset_lost_read: got activity after reset, expected reset values and no ack"); end
    grant[1] = 1'b1;
    exp_q.push_back('{1, model[1][6'h11]});
    do_read(1, 16'h0011, lat, d, v);
    grant[1] = 1'b0;
    e = exp_q.pop_front();
    tests_run++;
    if (lat != 6 || d !== e.data) begin
      tests_failed++;
      $display("FAIL reset_reinit: got lat=%0d data=%h, expected lat=6 data=%h", lat, d, e.data);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    test_reset();
    test_write_read();
    test_data_first();
    test_back_to_back();
    test_read_latency();
    test_split_delayed_grant();
    test_split_early_grant();
    test_split_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/target.md
# target

Bus-side responder (slave) for the serial-bus design: the counterpart of the initiator. Captures address/data/direction pulses delivered by the bus after arbitration, owns a small byte-wide register memory, and completes each transfer with `tgt_ack`. Reads complete either inline (ack + data in the same cycle) or as a split transaction (`tgt_split_ack`, bus released, later re-arbitration via `tgt_split_req`/`tgt_split_grant`).

## Interface
- `MEM_ADDR_W`, 6: memory index width; depth = 2^MEM_ADDR_W bytes; index = `tgt_addr_in[MEM_ADDR_W-1:0]`, upper bits ignored (bus decoder selects the target).
- `MEM_INIT_XOR`, 8'h00: reset content; `mem[i] = i[7:0] ^ MEM_INIT_XOR`.
- `READ_LATENCY`, 0: extra wait cycles before an inline read response (0..15).
- `SPLIT_EN`, 0: 1 = every read is split.
- `SPLIT_LATENCY`, 4: cycles held in split wait before requesting the bus (1..255).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tgt_addr_in` in 16: transfer address.
- `tgt_addr_in_valid` in 1: one-cycle address strobe.
- `tgt_data_in` in 8: write data.
- `tgt_data_in_valid` in 1: one-cycle write-data strobe.
- `tgt_rw` in 1: 1 = write, 0 = read; sampled with `tgt_addr_in_valid`.
- `tgt_ready` out 1: target can accept a new address.
- `tgt_ack` out 1: one-cycle transfer-complete pulse.
- `tgt_split_ack` out 1: one-cycle pulse, read deferred.
- `tgt_data_out` out 8: read data.
- `tgt_data_out_valid` out 1: one-cycle read-data strobe.
- `tgt_split_req` out 1: bus request to return split read data.
- `tgt_split_grant` in 1: bus granted for split response.

## Operation
- Reset: all outputs 0 except `tgt_ready = 1`; state S_IDLE; memory reloaded per `MEM_INIT_XOR`; capture flags cleared.
- States: S_IDLE, S_WR_COLLECT, S_WR_ACK, S_RD_DELAY, S_RD_RESP, S_SPLIT_WAIT, S_SPLIT_REQ, S_SPLIT_RESP.
- S_IDLE:
  - Addr strobe with rw=1: latch addr. If a data strobe arrives in the same cycle, or data was already latched, go to S_WR_ACK; else go to S_WR_COLLECT.
  - Data strobe alone in S_IDLE: latch data, set data flag, stay in S_IDLE (data may precede address).
  - Addr strobe with rw=0: latch addr, discard any latched data. SPLIT_EN=1 → S_SPLIT_WAIT. Else READ_LATENCY>0 → S_RD_DELAY. Else → S_RD_RESP.
- S_WR_COLLECT: wait for data strobe, then S_WR_ACK. Further address strobes are ignored.
- S_WR_ACK (one cycle): `mem[idx] <= data` on entry edge; `tgt_ack = 1`; clear flags; → S_IDLE.
- S_RD_DELAY: count READ_LATENCY cycles, then S_RD_RESP.
- S_RD_RESP (one cycle): `tgt_ack = tgt_data_out_valid = 1`, `tgt_data_out = mem[idx]`; → S_IDLE.
- S_SPLIT_WAIT: `tgt_split_ack = 1` in its first cycle only; count SPLIT_LATENCY cycles; → S_SPLIT_REQ.
- S_SPLIT_REQ: `tgt_split_req = 1` until `tgt_split_grant` is sampled high; → S_SPLIT_RESP.
- S_SPLIT_RESP (one cycle): `tgt_ack = tgt_data_out_valid = 1` with `mem[idx]`; `tgt_split_req = 0`; → S_IDLE.
- `tgt_ready = 1` only in S_IDLE and S_WR_COLLECT. Address strobes at any other time are ignored.
- `tgt_data_out` holds its last value outside response cycles. It is 0 after reset.
- A read of an index returns the value from any earlier completed write (read-after-write coherent).

## Timing
- All outputs are registered. The capture edge is the edge sampling the last required strobe.
- Write: `tgt_ack` is high in the cycle after the capture edge, i.e. 1 cycle latency.
- Inline read: ack + data high for 1 cycle, starting READ_LATENCY+1 cycles after the address edge.
- Split read:
  - `tgt_split_ack` high in cycle +1.
  - `tgt_split_req` rises at cycle +1+SPLIT_LATENCY.
  - ack + data are high in the cycle after grant is sampled.
- Grant already high when `tgt_split_req` rises: response in the next cycle.
- Reset mid-transaction: immediate return to reset values. `tgt_split_req` drops asynchronously. The pending read is lost and no ack is issued.

## Test plan
- Write 8'hAA to 16'h0012 (addr + data same cycle) → `tgt_ack` pulse 1 cycle later; subsequent read of 0x0012 returns 8'hAA.
- Read 16'h0034 after reset, SPLIT_EN=0, READ_LATENCY=0 → ack + `tgt_data_out_valid` with 8'h34, one cycle after the address strobe.
- Data strobe 8'h5C two cycles before addr 0x0003 with rw=1 → ack 1 cycle after the address strobe; `mem[3] = 8'h5C`.
- SPLIT_EN=1, SPLIT_LATENCY=4, read 0x0034 → `split_ack` at +1, `split_req` at +5; grant delayed 3 cycles → ack + data 8'h34 the cycle after grant; `split_req` then low.
- Address strobe while in S_SPLIT_REQ → ignored, memory unchanged, `tgt_ready` = 0.
- `rst_n` asserted during S_SPLIT_REQ → all outputs at reset values, `tgt_ready = 1`, a written location reads back its init value.
